// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 constants and FSM state types for the simulation memory slave.
//   AXI_FIXED / AXI_INCR / AXI_WRAP : AxBURST encodings
//   AXI_OKAY / AXI_SLVERR           : xRESP encodings
//   wr_state_t / rd_state_t         : write / read channel FSM states
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] AXI_FIXED  = 2'b00;
    localparam logic [1:0] AXI_INCR   = 2'b01;
    localparam logic [1:0] AXI_WRAP   = 2'b10;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// ---------------------------------------------------------------------------
// axi_burst_addr
// Combinational AXI4 next-beat address generator, one instance per channel.
//   addr      in  64  address of the current beat
//   size      in  3   AxSIZE, step = 1 << size bytes
//   len       in  8   AxLEN (beats - 1), sets the WRAP window
//   burst     in  2   AxBURST
//   next_addr out 64  address of the following beat
// FIXED holds the address. WRAP with a legal length (2/4/8/16 beats) wraps
// inside the aligned window; any other WRAP length and the reserved encoding
// behave as INCR.
// ---------------------------------------------------------------------------
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [63:0] next_addr
);

    logic [63:0] step;
    logic [63:0] incr_addr;
    logic [63:0] wrap_mask;
    logic        wrap_ok;

    always_comb begin
        step      = 64'd1 << size;
        incr_addr = addr + step;
        // Window is (len+1)*step bytes; it is a power of two when wrap_ok.
        wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr = incr_addr;
        if (burst == AXI_FIXED)
            next_addr = addr;
        else if (burst == AXI_WRAP && wrap_ok)
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end

endmodule

// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
// Simulation AXI4 slave memory (64-bit data, 8-bit IDs) backed by a
// doubleword array of 2^aw words mapped at byte address `base`.
// Read and write channels run independent FSMs and may overlap fully.
//   clk, rst                 clock / asynchronous active-high reset
//   s_axi_aw* / s_axi_awready write address channel (lock/cache/prot/qos ignored)
//   s_axi_w*  / s_axi_wready  write data channel
//   s_axi_b*  / s_axi_bready  write response channel
//   s_axi_ar* / s_axi_arready read address channel (lock/cache/prot/qos ignored)
//   s_axi_r*  / s_axi_rready  read data channel
// Parameters: base (word 0 byte address), aw (log2 depth in words),
//   latency (idle cycles between AR handshake and first R beat).
// Optional feature macro AXI_MEM_SLVERR_EN: out-of-range beats and
//   wlast/len mismatches answer SLVERR; errored writes are dropped and
//   errored reads return zero. Without it addresses alias by truncation.
// `mem` is a plain array so a bench can preload it hierarchically.
// ---------------------------------------------------------------------------
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter logic [63:0] base    = 64'h8000_0000,
    parameter int          aw      = 20,
    parameter int          latency = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  s_axi_awid,
    input  logic [63:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [7:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [7:0]  s_axi_arid,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [7:0]  s_axi_rid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

`ifdef AXI_MEM_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam logic [7:0] LAT = 8'(latency);

    logic [63:0] mem [0:(1 << aw) - 1];

    function automatic logic [aw-1:0] word_idx(input logic [63:0] a);
        return aw'((a - base) >> 3);
    endfunction

    function automatic logic in_range(input logic [63:0] a);
        return (a >= base) && (((a - base) >> (aw + 3)) == 64'd0);
    endfunction

    // Sideband fields carry no meaning for a flat memory.
    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t   w_state;
    logic [7:0]  w_id;
    logic [63:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [8:0]  w_cnt;      // one extra bit so overrun beats stay distinguishable
    logic        w_err;
    logic [63:0] w_next;
    logic        w_beat_err;
    logic        w_we;

    axi_burst_addr u_w_addr (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next)
    );

    assign w_beat_err = SLVERR_EN && !in_range(w_addr);
    // Beats beyond len are still accepted but never reach the array.
    assign w_we = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready &&
                  (w_cnt <= {1'b0, w_len}) && !w_beat_err;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++)
                if (s_axi_wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= 8'd0;
            s_axi_bresp   <= AXI_OKAY;
            w_id          <= 8'd0;
            w_addr        <= 64'd0;
            w_len         <= 8'd0;
            w_size        <= 3'd0;
            w_burst       <= 2'd0;
            w_cnt         <= 9'd0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_cnt         <= 9'd0;
                        w_err         <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && s_axi_wready) begin
                        w_addr <= w_next;
                        if (w_cnt != 9'h1FF)
                            w_cnt <= w_cnt + 9'd1;
                        if (w_beat_err)
                            w_err <= 1'b1;
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= (SLVERR_EN && (w_err || w_beat_err ||
                                             w_cnt != {1'b0, w_len})) ? AXI_SLVERR : AXI_OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t   r_state;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;
    logic [7:0]  r_wait;
    logic [63:0] r_next;
    logic [63:0] ld_addr;
    logic [63:0] ld_data;
    logic [1:0]  ld_resp;

    axi_burst_addr u_r_addr (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next)
    );

    // rdata is registered when a beat is first presented, so a write landing
    // on the same edge is not seen and the beat stays stable under stall.
    always_comb begin
        ld_addr = r_next;
        case (r_state)
            R_IDLE:  ld_addr = s_axi_araddr;
            R_WAIT:  ld_addr = r_addr;
            default: ld_addr = r_next;
        endcase
        ld_data = mem[word_idx(ld_addr)];
        ld_resp = AXI_OKAY;
        if (SLVERR_EN && !in_range(ld_addr)) begin
            ld_data = 64'd0;
            ld_resp = AXI_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= 8'd0;
            s_axi_rdata   <= 64'd0;
            s_axi_rresp   <= AXI_OKAY;
            r_addr        <= 64'd0;
            r_len         <= 8'd0;
            r_size        <= 3'd0;
            r_burst       <= 2'd0;
            r_cnt         <= 8'd0;
            r_wait        <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rid     <= s_axi_arid;
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_cnt         <= 8'd0;
                        r_wait        <= LAT;
                        s_axi_arready <= 1'b0;
                        if (LAT == 8'd0) begin
                            s_axi_rvalid <= 1'b1;
                            s_axi_rlast  <= (s_axi_arlen == 8'd0);
                            s_axi_rdata  <= ld_data;
                            s_axi_rresp  <= ld_resp;
                            r_state      <= R_DATA;
                        end else begin
                            r_state      <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    // Leaving on the edge where the count would reach zero.
                    if (r_wait <= 8'd1) begin
                        r_wait       <= 8'd0;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rlast  <= (r_len == 8'd0);
                        s_axi_rdata  <= ld_data;
                        s_axi_rresp  <= ld_resp;
                        r_state      <= R_DATA;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr      <= r_next;
                            r_cnt       <= r_cnt + 8'd1;
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                            s_axi_rdata <= ld_data;
                            s_axi_rresp <= ld_resp;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awid = 8'd0;    logic [63:0] awaddr = 64'd0; logic [7:0] awlen = 8'd0;
    logic [2:0]  awsize = 3'd0;  logic [1:0]  awburst = 2'd0; logic awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = 64'd0;  logic [7:0]  wstrb = 8'd0;   logic wlast = 1'b0; logic wvalid = 1'b0;
    logic        wready;
    logic [7:0]  bid;            logic [1:0]  bresp;          logic bvalid; logic bready = 1'b0;
    logic [7:0]  arid = 8'd0;    logic [63:0] araddr = 64'd0; logic [7:0] arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;  logic [1:0]  arburst = 2'd0; logic arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;            logic [63:0] rdata;          logic [1:0] rresp;
    logic        rlast;          logic        rvalid;         logic rready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [63:0] data; logic last; logic [1:0] resp; logic [7:0] id; } rbeat_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];
    logic [63:0] wbeat [0:15];

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one write burst; the B response is popped from exp_b and compared.
    task automatic write_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] id, input int nbeats,
                               input logic [7:0] strb, input int bstall);
        int t;
        bexp_t e;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 50);
        if (!awready) begin
            checks++; failures++; $display("FAIL aw_timeout: awready=%b required 1", awready);
            awvalid = 1'b0; return;
        end
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = wbeat[i]; wstrb = strb; wlast = (i == nbeats - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!wready && t < 50);
            if (!wready) begin
                checks++; failures++; $display("FAIL w_timeout: wready=%b required 1 beat %0d", wready, i);
                wvalid = 1'b0; wlast = 1'b0; return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (!bvalid) begin
            checks++; failures++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
            return;
        end
        for (int s = 0; s < bstall; s++) begin
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                failures++;
                $display("FAIL b_hold: bvalid=%b awready=%b required 1/0 stall %0d", bvalid, awready, s);
            end
            @(negedge clk);
        end
        bready = 1'b1;
        e = exp_b.pop_front();
        checks++;
        if (bid !== e.id || bresp !== e.resp) begin
            failures++;
            $display("FAIL bresp: bid=%h bresp=%h required bid=%h bresp=%h", bid, bresp, e.id, e.resp);
        end
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin
            failures++; $display("FAIL awready_after_b: awready=%b required 1", awready);
        end
    endtask

    // Drives one read burst; each R beat is popped from exp_r and compared.
    task automatic read_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [7:0] id,
                              input int stall_beat, input int stall_cycles, output int lat);
        int t, hs_cyc, first_cyc;
        logic [63:0] hd;
        logic hl;
        rbeat_t e;
        lat = -1;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        if (!arready) begin
            checks++; failures++; $display("FAIL ar_timeout: arready=%b required 1", arready);
            arvalid = 1'b0; exp_r.delete(); return;
        end
        hs_cyc = cyc;
        first_cyc = -1;
        @(posedge clk); #1 arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!rvalid && t < 50);
            if (!rvalid) begin
                checks++; failures++; $display("FAIL r_timeout: rvalid=%b required 1 beat %0d", rvalid, i);
                exp_r.delete(); return;
            end
            if (first_cyc < 0) first_cyc = cyc;
            if (i == stall_beat) begin
                hd = rdata; hl = rlast;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
                        failures++;
                        $display("FAIL r_hold: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                                 rvalid, rdata, rlast, hd, hl);
                    end
                end
            end
            rready = 1'b1;
            e = exp_r.pop_front();
            checks++;
            if (rdata !== e.data || rlast !== e.last || rresp !== e.resp || rid !== e.id) begin
                failures++;
                $display("FAIL rbeat%0d: data=%h last=%b resp=%h id=%h required %h %b %h %h",
                         i, rdata, rlast, rresp, rid, e.data, e.last, e.resp, e.id);
            end
            @(posedge clk); #1 rready = 1'b0;
        end
        lat = first_cyc - hs_cyc;
    endtask

    task automatic push_r(input logic [63:0] d, input logic l, input logic [1:0] r, input logic [7:0] id);
        rbeat_t e;
        e.data = d; e.last = l; e.resp = r; e.id = id;
        exp_r.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] id, input logic [1:0] r);
        bexp_t e;
        e.id = id; e.resp = r;
        exp_b.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bid, rid, bresp, rresp, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outs: aw=%b w=%b b=%b ar=%b r=%b last=%b bid=%h rid=%h bresp=%h rresp=%h rdata=%h required all 0",
                     awready, wready, bvalid, arready, rvalid, rlast, bid, rid, bresp, rresp, rdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: awready=%b arready=%b required 1 1", awready, arready);
        end
    endtask

    task automatic test_incr();
        int lat;
        for (int i = 0; i < 4; i++) wbeat[i] = 64'(i + 1);
        push_b(8'h5A, 2'b00);
        write_burst(BASE, 8'd3, 3'd3, 2'b01, 8'h5A, 4, 8'hFF, 0);
        for (int i = 0; i < 4; i++) push_r(64'(i + 1), i == 3, 2'b00, 8'h33);
        read_burst(BASE, 8'd3, 3'd3, 2'b01, 8'h33, -1, 0, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL read_latency: got %0d required 3", lat); end
    endtask

    task automatic test_wrap();
        int lat;
        for (int i = 0; i < 4; i++) wbeat[i] = 64'(10 + i);
        push_b(8'h01, 2'b00);
        write_burst(BASE, 8'd3, 3'd3, 2'b01, 8'h01, 4, 8'hFF, 0);
        push_r(64'd12, 1'b0, 2'b00, 8'h21);
        push_r(64'd13, 1'b0, 2'b00, 8'h21);
        push_r(64'd10, 1'b0, 2'b00, 8'h21);
        push_r(64'd11, 1'b1, 2'b00, 8'h21);
        read_burst(BASE + 64'h10, 8'd3, 3'd3, 2'b10, 8'h21, -1, 0, lat);
    endtask

    task automatic test_strb();
        int lat;
        wbeat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        push_b(8'h02, 2'b00);
        write_burst(BASE + 64'd40, 8'd0, 3'd3, 2'b01, 8'h02, 1, 8'hFF, 0);
        wbeat[0] = 64'hAAAA_AAAA_BBBB_BBBB;
        push_b(8'h03, 2'b00);
        write_burst(BASE + 64'd40, 8'd0, 3'd3, 2'b01, 8'h03, 1, 8'h0F, 0);
        push_r(64'hFFFF_FFFF_BBBB_BBBB, 1'b1, 2'b00, 8'h04);
        read_burst(BASE + 64'd40, 8'd0, 3'd3, 2'b01, 8'h04, -1, 0, lat);
    endtask

    task automatic test_fixed();
        int lat;
        wbeat[0] = 64'h999;
        push_b(8'h05, 2'b00);
        write_burst(BASE + 64'd72, 8'd0, 3'd3, 2'b01, 8'h05, 1, 8'hFF, 0);
        wbeat[0] = 64'h111; wbeat[1] = 64'h222;
        push_b(8'h06, 2'b00);
        write_burst(BASE + 64'd64, 8'd1, 3'd3, 2'b00, 8'h06, 2, 8'hFF, 0);
        push_r(64'h222, 1'b0, 2'b00, 8'h07);
        push_r(64'h999, 1'b1, 2'b00, 8'h07);
        read_burst(BASE + 64'd64, 8'd1, 3'd3, 2'b01, 8'h07, -1, 0, lat);
    endtask

    // Three beats against len=1: the third is accepted but not written.
    task automatic test_overrun();
        int lat;
        wbeat[0] = 64'h2222;
        push_b(8'h08, 2'b00);
        write_burst(BASE + 64'd176, 8'd0, 3'd3, 2'b01, 8'h08, 1, 8'hFF, 0);
        wbeat[0] = 64'hA0; wbeat[1] = 64'hA1; wbeat[2] = 64'hA2;
`ifdef AXI_MEM_SLVERR_EN
        push_b(8'h09, 2'b10);
`else
        push_b(8'h09, 2'b00);
`endif
        write_burst(BASE + 64'd160, 8'd1, 3'd3, 2'b01, 8'h09, 3, 8'hFF, 0);
        push_r(64'hA0, 1'b0, 2'b00, 8'h0A);
        push_r(64'hA1, 1'b0, 2'b00, 8'h0A);
        push_r(64'h2222, 1'b1, 2'b00, 8'h0A);
        read_burst(BASE + 64'd160, 8'd2, 3'd3, 2'b01, 8'h0A, -1, 0, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        for (int i = 0; i < 4; i++) wbeat[i] = 64'hC0DE_0000 + 64'(i);
        push_b(8'h0B, 2'b00);
        write_burst(BASE + 64'd320, 8'd3, 3'd3, 2'b01, 8'h0B, 4, 8'hFF, 4);
        for (int i = 0; i < 4; i++) push_r(64'hC0DE_0000 + 64'(i), i == 3, 2'b00, 8'h0C);
        read_burst(BASE + 64'd320, 8'd3, 3'd3, 2'b01, 8'h0C, 1, 5, lat);
    endtask

    // Word 0 holds 10 from the WRAP setup; 0x70000000 truncates onto it.
    task automatic test_oor();
        int lat;
`ifdef AXI_MEM_SLVERR_EN
        push_r(64'd0, 1'b1, 2'b10, 8'h0D);
`else
        push_r(64'd10, 1'b1, 2'b00, 8'h0D);
`endif
        read_burst(64'h7000_0000, 8'd0, 3'd3, 2'b01, 8'h0D, -1, 0, lat);
    endtask

    task automatic test_reset_mid();
        int t, beat, lat;
        @(posedge clk); #1;
        arid = 8'h0E; araddr = BASE; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        @(posedge clk); #1 arvalid = 1'b0;
        beat = 0; t = 0;
        while (beat < 2 && t < 50) begin
            @(negedge clk); t++;
            rready = 1'b1;
            if (rvalid) begin
                checks++;
                if (rdata !== 64'(10 + beat)) begin
                    failures++; $display("FAIL mid_beat%0d: rdata=%h required %h", beat, rdata, 64'(10 + beat));
                end
                beat++;
            end
        end
        @(negedge clk);
        rready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || beat != 2) begin
            failures++;
            $display("FAIL mid_reset: rvalid=%b arready=%b beats=%0d required 0 0 2", rvalid, arready, beat);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL arready_after_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        for (int i = 0; i < 4; i++) push_r(64'(10 + i), i == 3, 2'b00, 8'h0F);
        read_burst(BASE, 8'd3, 3'd3, 2'b01, 8'h0F, -1, 0, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL latency_after_reset: got %0d required 3", lat); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_strb();
        test_fixed();
        test_overrun();
        test_backpressure();
        test_oor();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Simulation-side AXI4 slave memory that terminates the core's 64-bit master AXI port (8-bit IDs). It serves read and write bursts from an internal doubleword array mapped at a fixed base address. It sits in the testbench top beside the core instance, and its read and write channels operate independently.

## Interface
- `base`, 64'h80000000, byte address of array word 0
- `aw`, 20, log2 of array depth in 64-bit words
- `latency`, 2, idle cycles between AR handshake and first R beat (0 allowed)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}`  in  8/64/8/3/2/1/4/3/4/1  write address; lock/cache/prot/qos ignored
- `s_axi_awready`  out  1
- `s_axi_w{data,strb,last,valid}`  in  64/8/1/1
- `s_axi_wready`  out  1
- `s_axi_b{id,resp,valid}`  out  8/2/1
- `s_axi_bready`  in  1
- `s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}`  in  same widths as AW
- `s_axi_arready`  out  1
- `s_axi_r{id,data,resp,last,valid}`  out  8/64/2/1/1
- `s_axi_rready`  in  1

## Operation
- Word index is `(addr - base) >> 3`, truncated to `aw` bits. A request is in range iff `base <= addr < base + 8<<aw`.
- Write FSM has three states:
  - W_IDLE: awready=1; on AW handshake, latch id/addr/len/size/burst, clear beat count, go to W_DATA.
  - W_DATA: wready=1; each W handshake writes bytes where strb[i]=1 into the current word, advances the address, increments the count. The beat with wlast=1 goes to W_RESP.
  - W_RESP: bvalid=1 with bid=latched awid; on bready, go to W_IDLE.
- Beats after count exceeds len and before wlast: accepted but not written.
- Read FSM has three states:
  - R_IDLE: arready=1; on AR handshake, latch fields and load the wait counter with `latency`. Go to R_WAIT, or go directly to R_DATA when latency=0.
  - R_WAIT: decrement the counter; at 0 go to R_DATA.
  - R_DATA: rvalid=1, rid=latched arid, rdata=array word at current address, rlast=(count==len). On handshake, advance the address and count. After the last beat, go to R_IDLE.
- Next address, with step = 1<<size:
  - FIXED (2'b00): unchanged.
  - INCR (2'b01): add step.
  - WRAP (2'b10): add step, wrapping within the aligned (len+1)*step window. WRAP len not in {1,3,7,15} is treated as INCR.
  - Burst 2'b11 is treated as INCR.
- Same-cycle write beat and read beat to the same word: the read returns the old data; the write takes effect at the edge.
- Reset, mid-burst or otherwise, returns both FSMs to idle. In-flight bursts are dropped and array contents are kept.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, bresp, rresp = 0; rdata = 0.
- awready/arready are registered, asserting the first cycle after reset deasserts.
- Write: AW handshake at cycle N → wready at N+1. One beat per cycle while wvalid. Last beat at cycle M → bvalid at M+1. B handshake at cycle K → awready at K+1.
- Read: AR handshake at N → first rvalid at N+1+latency. Beats are back-to-back while rready. rvalid/rdata/rlast are held stable while rready=0. Last-beat handshake at K → arready at K+1.
- Throughput: one beat per cycle per channel; read and write bursts may overlap fully.

## Configuration
- `AXI_MEM_SLVERR_EN` defined:
  - Out-of-range requests return resp=2'b10 (SLVERR). Checked per beat; the burst's B carries SLVERR if any beat erred.
  - A wlast/len mismatch also yields SLVERR on B.
  - Errored write beats are not written; errored read beats return rdata=0.
- Undefined: resp is always 2'b00. Out-of-range addresses alias by truncation to `aw` bits, and mismatches are silent.

## Structure
- Package `axi_pkg` holds:
  - burst constants `AXI_FIXED`, `AXI_INCR`, `AXI_WRAP`
  - resp constants `AXI_OKAY`, `AXI_SLVERR`
  - the write-FSM and read-FSM state enums
- Sub-module `axi_burst_addr` is combinational (addr, size, len, burst → next addr) and is instantiated once per channel.
- Memory is a plain `logic [63:0]` array with 2^aw entries, writable by hierarchical reference for preload.

## Test plan
- INCR write, len=3, size=3, addr 0x80000000, data 1..4, strb 0xFF → bresp 0, bid echoes 0x5A. A follow-up INCR read returns 1,2,3,4, rlast only on beat 4, first rvalid exactly 3 cycles after AR with latency=2.
- WRAP read, len=3, size=3, addr 0x80000010 over words 10..13 → beats return words 12,13,10,11.
- Write with strb 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over word 0xFFFFFFFF_FFFFFFFF → readback 0xFFFFFFFF_BBBBBBBB.
- rready low 5 cycles mid-burst, and bready low 4 cycles → outputs held stable, no beat lost, awready stays 0 until B handshake.
- With `AXI_MEM_SLVERR_EN`, read at 0x70000000 → rresp 2'b10, rdata 0. Without the macro → rresp 0 and aliased data.
- Assert rst during beat 2 of a len=7 read → rvalid 0 immediately, arready 1 the cycle after release, and a new read completes normally.
